seq_alu: RTL
============

# seq_alu

Parametrised, handshaked successor to the combinational datapath ALU. Keeps the existing 4-bit ALUControl encodings for the single-cycle operations and adds iterative unsigned multiply and divide, plus NZCV flags. It registers one operation at a time behind valid/ready handshakes, so the datapath can stall on long operations. It sits between the register-read stage and write-back in the multi-cycle core.

## Interface
- WIDTH, 64, operand/result width in bits; must be ≥ 2.
- CNTW, $clog2(WIDTH+1), iteration-counter width; derived, not overridden.

- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-low; clears all state while low.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- ALUControl  in  4  operation select.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes the result this cycle.
- result  out  WIDTH  operation result.
- zero  out  1  result == 0.
- negative  out  1  result[WIDTH-1].
- carry  out  1  ADD: carry-out; SUB: no-borrow (a ≥ b unsigned); otherwise 0.
- overflow  out  1  signed overflow for ADD/SUB; otherwise 0.

## Operation
- Opcodes:
  - 0000 AND.
  - 0001 OR.
  - 0010 ADD.
  - 0110 SUB (a − b).
  - 0111 pass b.
  - 1100 XOR.
  - 1000 MUL: low WIDTH bits of a×b, shift-add, one bit per cycle.
  - 1011 UDIV: a÷b unsigned quotient, restoring, one bit per cycle.
  - Any other code: pass a.
- The operation is captured at acceptance; inputs are don't-care afterwards.
- FSM states:
  - IDLE: in_ready = 1.
    - Accepting a single-cycle opcode computes it and goes to DONE.
    - Accepting MUL or UDIV loads the working registers, sets counter = WIDTH, and goes to BUSY.
  - BUSY: performs one iteration per cycle and decrements the counter.
    - On the iteration where the counter goes 1→0, goes to DONE with the result latched.
  - DONE: out_valid = 1; result and flags are held stable.
    - out_ready = 1 with no new accept: go to IDLE.
    - out_ready = 1 with in_valid = 1: accept the new operation in the same cycle (back-to-back).
- in_ready = (state == IDLE) || (state == DONE && out_ready).
- UDIV with b = 0: result = 0 and all flags 0. Still takes WIDTH cycles so latency is uniform.
- MUL: the high product bits are discarded; flags are Z and N only.
- Arithmetic flags:
  - ADD computes a WIDTH+1-bit sum; carry is the top bit.
  - SUB computes a + ~b + 1.
  - overflow = sign(a) and sign(b′) are equal and differ from sign(result), where b′ = b for ADD and ~b for SUB.
- Logic and pass operations: carry = overflow = 0.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, result 0, all flags 0, counter 0.
- Reset asserted mid-BUSY or mid-DONE: the operation is abandoned, returns to IDLE, and no out_valid is produced.
- Latency, counted from the accept edge k:
  - Single-cycle ops: out_valid high in cycle k+1.
  - MUL/UDIV: out_valid high in cycle k+WIDTH+1 (WIDTH BUSY cycles).
- Throughput:
  - Single-cycle ops: one per cycle when out_ready is held high.
  - MUL/UDIV: one per WIDTH+1 cycles.
- Back-pressure: out_valid stays high and result/flags stay constant until out_ready is sampled high. in_ready stays 0 during that time.
- in_valid while busy or stalled is ignored; nothing is queued.
- All outputs are registered except in_ready, which is combinational from state and out_ready.

## Test plan
- Reset/idle: hold reset low 3 cycles, then release → in_ready = 1, out_valid = 0, result = 0, flags = 0.
- ADD overflow (WIDTH = 64): a = 0x7FFF_FFFF_FFFF_FFFF, b = 1, op 0010 → next cycle result = 0x8000_0000_0000_0000, N = 1, V = 1, C = 0, Z = 0.
- SUB equal: a = b = 5, op 0110 → result 0, Z = 1, C = 1, V = 0.
- Back-to-back: out_ready held high; AND, OR, XOR, pass-b offered on consecutive cycles → four results on four consecutive cycles, in order.
- MUL with stall: a = 123456789, b = 1000, op 1000, out_ready low → out_valid rises exactly 65 cycles after accept. result = 123456789000, held unchanged for 5 stall cycles. in_ready = 0 throughout.
- UDIV divide-by-zero, then reset mid-op:
  - a = 100, b = 7, op 1011 → result 14 after 65 cycles.
  - a = 100, b = 0 → result 0 after 65 cycles, all flags 0.
  - Start UDIV, assert reset at cycle 10 → out_valid never rises; in_ready = 1 after reset release.

Source files
------------

// File: rtl/seq_alu.sv
// Handshaked sequential ALU: single-cycle logic/add/sub ops plus iterative
// shift-add multiply and restoring divide, with registered result and NZCV flags.
module seq_alu #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow
);

    localparam int CNTW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_PASSB = 4'b0111;
    localparam logic [3:0] OP_XOR   = 4'b1100;
    localparam logic [3:0] OP_MUL   = 4'b1000;
    localparam logic [3:0] OP_UDIV  = 4'b1011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              is_div_q, is_div_d;
    logic [WIDTH-1:0]  x_q, x_d;       // MUL multiplicand / UDIV dividend->quotient
    logic [WIDTH-1:0]  y_q, y_d;       // MUL multiplier / UDIV divisor
    logic [WIDTH-1:0]  r_q, r_d;       // MUL accumulator / UDIV partial remainder
    logic [WIDTH-1:0]  result_q, result_d;
    logic              zero_q, zero_d;
    logic              neg_q, neg_d;
    logic              carry_q, carry_d;
    logic              ovf_q, ovf_d;

    logic              accept;
    logic              is_sub;
    logic [WIDTH-1:0]  b_op;
    logic [WIDTH:0]    sum_ext;
    logic [WIDTH-1:0]  sc_result;
    logic              sc_carry;
    logic              sc_ovf;

    logic [WIDTH-1:0]  mul_acc_next;
    logic [WIDTH:0]    div_shift;
    logic [WIDTH:0]    div_diff;
    logic              div_ge;
    logic [WIDTH-1:0]  iter_r;
    logic [WIDTH-1:0]  iter_x;
    logic [WIDTH-1:0]  fin_val;

    assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    // Single-cycle datapath; SUB reuses the adder as a + ~b + 1.
    always_comb begin
        is_sub    = (ALUControl == OP_SUB);
        b_op      = is_sub ? ~b : b;
        sum_ext   = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        sc_result = a;
        sc_carry  = 1'b0;
        sc_ovf    = 1'b0;
        case (ALUControl)
            OP_AND:   sc_result = a & b;
            OP_OR:    sc_result = a | b;
            OP_XOR:   sc_result = a ^ b;
            OP_PASSB: sc_result = b;
            OP_ADD, OP_SUB: begin
                sc_result = sum_ext[WIDTH-1:0];
                sc_carry  = sum_ext[WIDTH];
                sc_ovf    = (a[WIDTH-1] == b_op[WIDTH-1]) &&
                            (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            default:  sc_result = a;
        endcase
    end

    // One iteration of shift-add multiply and of restoring divide.
    always_comb begin
        mul_acc_next = y_q[0] ? (r_q + x_q) : r_q;
        div_shift    = {r_q, x_q[WIDTH-1]};
        div_diff     = div_shift - {1'b0, y_q};
        div_ge       = ~div_diff[WIDTH];
        if (is_div_q) begin
            iter_r = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            iter_x = {x_q[WIDTH-2:0], div_ge};
        end else begin
            iter_r = mul_acc_next;
            iter_x = {x_q[WIDTH-2:0], 1'b0};
        end
        fin_val = is_div_q ? iter_x : iter_r;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        x_d      = x_q;
        y_d      = y_q;
        r_d      = r_q;
        result_d = result_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE && out_ready) begin
                    state_d = S_IDLE;
                end
                if (accept) begin
                    if (ALUControl == OP_MUL || ALUControl == OP_UDIV) begin
                        is_div_d = (ALUControl == OP_UDIV);
                        x_d      = a;
                        y_d      = b;
                        r_d      = '0;
                        cnt_d    = CNTW'(WIDTH);
                        state_d  = S_BUSY;
                    end else begin
                        result_d = sc_result;
                        zero_d   = (sc_result == '0);
                        neg_d    = sc_result[WIDTH-1];
                        carry_d  = sc_carry;
                        ovf_d    = sc_ovf;
                        state_d  = S_DONE;
                    end
                end
            end
            S_BUSY: begin
                r_d   = iter_r;
                x_d   = iter_x;
                y_d   = is_div_q ? y_q : (y_q >> 1);
                cnt_d = cnt_q - CNTW'(1);
                if (cnt_q == CNTW'(1)) begin
                    state_d = S_DONE;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    // Divide by zero still runs all iterations; its answer is forced to 0, flags clear.
                    if (is_div_q && (y_q == '0)) begin
                        result_d = '0;
                        zero_d   = 1'b0;
                        neg_d    = 1'b0;
                    end else begin
                        result_d = fin_val;
                        zero_d   = (fin_val == '0);
                        neg_d    = fin_val[WIDTH-1];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            r_q      <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            x_q      <= x_d;
            y_q      <= y_d;
            r_q      <= r_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
        end
    end

    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign negative  = neg_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;

endmodule
